// File: rtl/mips_regfile.sv
// MIPS 32-entry register file: two combinational read ports, one write port, r0 hardwired to 0.
// Latency: reads are zero-cycle with write-to-read bypass; writes commit on the rising clock edge.
// Backpressure: none; one write per cycle is always accepted, and reset drops any concurrent write.
module mips_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [7:0]        wr_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_fire;

  // A write commits only when enabled, not targeting r0, and reset is low.
  // The same qualifier gates the bypass so the two can never disagree.
  assign wr_fire = wr_en && (wr_addr != '0) && !reset;

  // Register array: cleared by reset, otherwise updated by committed writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Debug count of committed writes; wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
    end else if (wr_fire) begin
      wr_count <= wr_count + 8'd1;
    end
  end

  // Operand A read: zero during reset or for r0, bypassed from the write port on an address match.
  always_comb begin
    rs_data = '0;
    if (!reset && (rs_addr != '0)) begin
      if (wr_fire && (rs_addr == wr_addr)) begin
        rs_data = wr_data;
      end else begin
        rs_data = regs[rs_addr];
      end
    end
  end

  // Operand B read: same rules as operand A, evaluated independently.
  always_comb begin
    rt_data = '0;
    if (!reset && (rt_addr != '0)) begin
      if (wr_fire && (rt_addr == wr_addr)) begin
        rt_data = wr_data;
      end else begin
        rt_data = regs[rt_addr];
      end
    end
  end

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// The reference model is a plain array updated by the bench's own write calls.
module tb_mips_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  wr_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];

  mips_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, leaving time before the next edge for drive and sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present a write for one cycle and mirror it into the model.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  initial begin
    int exp_cnt;
    logic [4:0] a;
    logic [31:0] d;

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rs_addr = 5'd4;
    rt_addr = 5'd9;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Single reset cycle, outputs forced to 0 while reset is high.
    tick();
    settle();
    chk("rs_in_reset", rs_data, 32'h0);
    chk("rt_in_reset", rt_data, 32'h0);
    reset = 1'b0;
    settle();

    // Sweep all addresses after reset.
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      settle();
      chk($sformatf("sweep_rs_%0d", i), rs_data, 32'h0);
      chk($sformatf("sweep_rt_%0d", 31 - i), rt_data, 32'h0);
    end
    chk("count_after_reset", {24'h0, wr_count}, 32'h0);

    // Write r5, read on both ports the next cycle.
    do_write(5'd5, 32'h0000_00FF);
    rs_addr = 5'd5;
    rt_addr = 5'd5;
    settle();
    chk("r5_rs", rs_data, 32'h0000_00FF);
    chk("r5_rt", rt_data, 32'h0000_00FF);
    chk("count_r5", {24'h0, wr_count}, 32'd1);

    // Write to r0 is discarded, no bypass, no count.
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hDEAD_BEEF;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    settle();
    chk("r0_same_rs", rs_data, 32'h0);
    chk("r0_same_rt", rt_data, 32'h0);
    tick();
    wr_en = 1'b0;
    settle();
    chk("r0_next_rs", rs_data, 32'h0);
    chk("count_r0", {24'h0, wr_count}, 32'd1);

    // Bypass: r7 = 1111_1111, r8 = 8888_8888, then overwrite r7 while reading it.
    do_write(5'd7, 32'h1111_1111);
    do_write(5'd8, 32'h8888_8888);
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h2222_2222;
    rs_addr = 5'd7;
    rt_addr = 5'd8;
    settle();
    chk("byp_rs", rs_data, 32'h2222_2222);
    chk("byp_rt_other", rt_data, 32'h8888_8888);
    rt_addr = 5'd7;
    settle();
    chk("byp_both_rs", rs_data, 32'h2222_2222);
    chk("byp_both_rt", rt_data, 32'h2222_2222);
    tick();
    model[7] = 32'h2222_2222;
    // No bypass with wr_en low even though the address matches.
    wr_en   = 1'b0;
    wr_addr = 5'd7;
    wr_data = 32'h3333_3333;
    settle();
    chk("byp_next_rs", rs_data, 32'h2222_2222);
    chk("nobyp_rt", rt_data, 32'h2222_2222);
    chk("count_byp", {24'h0, wr_count}, 32'd4);

    // Back-to-back writes to the same register keep the last one.
    do_write(5'd9, 32'h0000_0001);
    do_write(5'd9, 32'h0000_0002);
    rs_addr = 5'd9;
    settle();
    chk("b2b_r9", rs_data, 32'h0000_0002);
    chk("count_b2b", {24'h0, wr_count}, 32'd6);

    // Reset with a concurrent write: reset dominates.
    do_write(5'd3, 32'hA5A5_A5A5);
    rs_addr = 5'd3;
    rt_addr = 5'd3;
    settle();
    chk("r3_pre", rs_data, 32'hA5A5_A5A5);
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h5A5A_5A5A;
    settle();
    chk("rst_rs", rs_data, 32'h0);
    chk("rst_rt", rt_data, 32'h0);
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    settle();
    chk("r3_post", rs_data, 32'h0);
    rt_addr = 5'd5;
    settle();
    chk("r5_post", rt_data, 32'h0);
    chk("count_post_rst", {24'h0, wr_count}, 32'd0);

    // 256 round-robin writes over r1..r31: count wraps to 0.
    exp_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      a = 5'((i % 31) + 1);
      d = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
      do_write(a, d);
      exp_cnt = (exp_cnt + 1) % 256;
      if (i == 254) begin
        settle();
        chk("count_255", {24'h0, wr_count}, 32'd255);
      end
    end
    settle();
    chk("count_wrap", {24'h0, wr_count}, 32'(exp_cnt));
    for (int i = 1; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(32 - i);
      settle();
      chk($sformatf("final_rs_%0d", i), rs_data, model[i]);
      chk($sformatf("final_rt_%0d", 32 - i), rt_data, model[32 - i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
